// File: rtl/pixel_frame_writer.sv
// Frame-buffer writer: buffers RGB888 pixels from the shader, converts them to RGB565
// and writes them at linear raster addresses through a req/ack memory port.
module pixel_frame_writer #(
  parameter int H_RES      = 32,
  parameter int V_RES      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_wr_en,
  input  logic [2:0][7:0]      pixel_in,
  output logic                 in_full,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_data,
  input  logic                 mem_ack,
  output logic                 frame_done,
  output logic                 overflow,
  output logic [0:0]           state_debug
);

  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int FRAME_PIXELS = H_RES * V_RES;

  localparam logic [CNT_W-1:0]     CNT_FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_THRESHOLD = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR     = ADDR_BITS'(FRAME_PIXELS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Handshake: a write is transferred on a rising clock edge where mem_req=1 and
  // mem_ack=1; mem_addr/mem_data hold steady from mem_req rising until that edge.

  logic [23:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 push_q;
  logic                 head_ready;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 accept;
  logic [0:0]           state;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [23:0]          head;
  logic [15:0]          head_rgb565;

  // A freshly written entry becomes readable one cycle after its push edge.
  assign head_ready  = (count != '0) && !((count == CNT_W'(1)) && push_q);
  assign pop         = (state == ST_IDLE) && head_ready;
  assign push        = in_wr_en && ((count != CNT_FULL) || pop);
  assign drop        = in_wr_en && (count == CNT_FULL) && !pop;
  assign accept      = (state == ST_REQ) && mem_ack;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

  assign head        = fifo_mem[rd_ptr];
  assign head_rgb565 = {head[7:3], head[15:10], head[23:19]};

  assign mem_req     = (state == ST_REQ);
  assign state_debug = state;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= pixel_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_q   <= 1'b0;
      in_full  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_next;
      push_q  <= push;
      in_full <= (count_next >= CNT_THRESHOLD);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      addr_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && (addr_cnt == LAST_ADDR);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            mem_data <= head_rgb565;
            mem_addr <= addr_cnt;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + ADDR_BITS'(1);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Self-checking bench for pixel_frame_writer: expected {addr, rgb565} writes are queued
// as pixels are driven and compared when the memory port transfers them.
module tb_pixel_frame_writer;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_wr_en = 1'b0;
  logic [2:0][7:0] pixel_in = '0;
  logic            mem_ack = 1'b0;
  logic            in_full;
  logic            mem_req;
  logic [9:0]      mem_addr;
  logic [15:0]     mem_data;
  logic            frame_done;
  logic            overflow;
  logic [0:0]      state_debug;

  int         checks = 0;
  int         failures = 0;
  logic [25:0] exp_q[$];
  logic [9:0] exp_addr = '0;
  logic       expect_done = 1'b0;
  int         done_count = 0;

  always #5 clock = ~clock;

  pixel_frame_writer #(
    .H_RES(32), .V_RES(32), .FIFO_DEPTH(8), .ADDR_BITS(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_wr_en(in_wr_en),
    .pixel_in(pixel_in),
    .in_full(in_full),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ack(mem_ack),
    .frame_done(frame_done),
    .overflow(overflow),
    .state_debug(state_debug)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    logic [25:0] e;
    if (!reset) begin
      if (expect_done) begin
        check("frame_done_after_last", frame_done, 1);
        expect_done = 1'b0;
      end
      if (frame_done) done_count++;
      if (mem_req && mem_ack) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[25:16]);
          check("write_data", mem_data, e[15:0]);
        end
        if (mem_addr == 10'd1023) expect_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    in_wr_en = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    expect_done = 1'b0;
    #6 reset = 1'b0;
    tick();
  endtask

  task automatic drive_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input bit accepted);
    in_wr_en = 1'b1;
    pixel_in[0] = r;
    pixel_in[1] = g;
    pixel_in[2] = b;
    if (accepted) begin
      exp_q.push_back({exp_addr, to565(r, g, b)});
      exp_addr++;
    end
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic drive_random(input bit accepted);
    drive_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), accepted);
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int n = 0; n < budget && !mem_req; n++) tick();
    check(tag, mem_req, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  held_addr;
    logic [15:0] held_data;
    int          sent;

    // Reset values and single-pixel latency.
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_outputs", {in_full, frame_done, overflow, mem_addr, mem_data}, 0);
    do_reset();
    check("rst_release_outputs", {in_full, mem_req, frame_done, overflow, mem_addr, mem_data}, 0);
    mem_ack = 1'b1;
    drive_pixel(8'hFF, 8'h80, 8'h10, 1'b1);
    check("lat_edge_n", mem_req, 0);
    tick();
    check("lat_edge_n1", mem_req, 0);
    tick();
    check("lat_edge_n2", mem_req, 1);
    check("single_addr", mem_addr, 0);
    check("single_data", mem_data, 16'hFC02);
    tick();
    tick();
    check("single_overflow", overflow, 0);
    check("single_idle", mem_req, 0);

    // Memory stall for five cycles keeps address/data stable.
    mem_ack = 1'b0;
    drive_pixel(8'h12, 8'h34, 8'h56, 1'b1);
    wait_req("stall_req_timeout", 10);
    held_addr = mem_addr;
    held_data = mem_data;
    check("stall_addr_first", held_addr, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_held", mem_req, 1);
      check("stall_addr_held", mem_addr, held_addr);
      check("stall_data_held", mem_data, held_data);
    end
    mem_ack = 1'b1;
    tick();
    tick();
    check("stall_req_dropped", mem_req, 0);
    drive_pixel(8'hA5, 8'h5A, 8'hC3, 1'b1);
    wait_drain("stall_next_drain", 20);

    // Full frame with in_full honoured and memory always accepting.
    do_reset();
    done_count = 0;
    mem_ack = 1'b1;
    sent = 0;
    for (int n = 0; n < 20000 && sent < 1024; n++) begin
      if (!in_full && $urandom_range(0, 3) != 0) begin
        drive_random(1'b1);
        sent++;
      end else begin
        tick();
      end
    end
    check("frame_all_sent", sent, 1024);
    wait_drain("frame_drain", 100);
    tick();
    tick();
    check("frame_done_once", done_count, 1);
    check("frame_overflow", overflow, 0);
    drive_random(1'b1);
    wait_drain("frame_wrap_drain", 20);
    check("frame_done_no_repeat", done_count, 1);

    // Push coinciding with pop while the FIFO holds eight entries.
    do_reset();
    mem_ack = 1'b0;
    drive_random(1'b1);
    wait_req("pp_req_timeout", 10);
    for (int i = 0; i < 8; i++) drive_random(1'b1);
    check("pp_in_full_at_8", in_full, 1);
    check("pp_overflow_before", overflow, 0);
    mem_ack = 1'b1;
    tick();
    drive_random(1'b1);
    check("pp_overflow_after", overflow, 0);
    wait_drain("pp_drain", 60);
    check("pp_overflow_end", overflow, 0);

    // Burst of ten pixels with memory stalled: two are dropped.
    do_reset();
    mem_ack = 1'b0;
    drive_random(1'b1);
    wait_req("ovf_req_timeout", 10);
    for (int i = 0; i < 10; i++) begin
      drive_random(i < 8);
      if (i == 5) check("ovf_in_full_at_6", in_full, 0);
      if (i == 6) check("ovf_in_full_at_7", in_full, 1);
      if (i == 7) check("ovf_clear_at_8", overflow, 0);
    end
    check("ovf_set", overflow, 1);
    mem_ack = 1'b1;
    wait_drain("ovf_drain", 60);
    repeat (4) tick();
    check("ovf_no_extra_req", mem_req, 0);
    check("ovf_sticky", overflow, 1);

    // Reset during an outstanding request at address 5.
    do_reset();
    check("rst2_overflow_cleared", overflow, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) drive_random(1'b1);
    wait_drain("rst2_pre_drain", 40);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) drive_random(1'b1);
    wait_req("rst2_req_timeout", 10);
    check("rst2_addr5", mem_addr, 5);
    #2 reset = 1'b1;
    #1;
    check("rst2_async_drop", mem_req, 0);
    exp_q.delete();
    exp_addr = '0;
    #3 reset = 1'b0;
    tick();
    mem_ack = 1'b1;
    repeat (4) tick();
    check("rst2_fifo_empty", mem_req, 0);
    drive_random(1'b1);
    wait_drain("rst2_restart_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
